// File: rtl/branch_predictor.sv
// branch_predictor: bimodal/gshare 2-bit PHT with direct-mapped BTB, zero-latency lookup, resolve-time update and branch/mispredict counters
module branch_predictor #(
  parameter int PHT_IDX_W = 8,
  parameter int BTB_IDX_W = 6,
  parameter int MODE      = 0,
  parameter int GHR_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          lk_pc,
  output logic                 lk_pred_taken,
  output logic                 lk_btb_hit,
  output logic [31:0]          lk_target,
  output logic [PHT_IDX_W-1:0] lk_pht_idx,
  input  logic                 upd_en,
  input  logic [31:0]          upd_pc,
  input  logic [PHT_IDX_W-1:0] upd_pht_idx,
  input  logic                 upd_taken,
  input  logic [31:0]          upd_target,
  input  logic                 upd_mispred,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispreds
);
  localparam int PN = 1 << PHT_IDX_W;
  localparam int BN = 1 << BTB_IDX_W;
  localparam int TW = 30 - BTB_IDX_W;
  logic [1:0]           pht_q [PN];
  logic [BN-1:0]        btb_v_q;
  logic [TW-1:0]        btb_tag_q [BN];
  logic [31:0]          btb_tgt_q [BN];
  logic [GHR_W-1:0]     ghr_q, ghr_d;
  logic [31:0]          br_q, br_d, mp_q, mp_d;
  logic [1:0]           pht_cur, pht_d;
  logic [BTB_IDX_W-1:0] lk_bi, up_bi;
  logic                 unused_ok;
  assign unused_ok = ^{lk_pc[1:0], upd_pc[1:0]};
  always_comb begin
    lk_bi         = lk_pc[BTB_IDX_W+1:2];
    up_bi         = upd_pc[BTB_IDX_W+1:2];
    lk_pht_idx    = (MODE == 1) ? lk_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_q) : lk_pc[PHT_IDX_W+1:2];
    lk_btb_hit    = reset && btb_v_q[lk_bi] && (btb_tag_q[lk_bi] == lk_pc[31:BTB_IDX_W+2]);
    lk_pred_taken = lk_btb_hit && pht_q[lk_pht_idx][1];
    lk_target     = lk_btb_hit ? btb_tgt_q[lk_bi] : lk_pc + 32'd4;
    pht_cur       = pht_q[upd_pht_idx];
    pht_d         = upd_taken ? ((pht_cur == 2'b11) ? pht_cur : pht_cur + 2'd1)
                              : ((pht_cur == 2'b00) ? pht_cur : pht_cur - 2'd1);
    ghr_d         = GHR_W'({ghr_q, upd_taken});
    br_d          = (&br_q) ? br_q : br_q + 32'd1;
    mp_d          = (upd_mispred && !(&mp_q)) ? mp_q + 32'd1 : mp_q;
    stat_branches = br_q;
    stat_mispreds = mp_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PN; i++) pht_q[i] <= 2'b01;
      btb_v_q <= '0;
      ghr_q   <= '0;
      br_q    <= '0;
      mp_q    <= '0;
    end else if (upd_en) begin
      pht_q[upd_pht_idx] <= pht_d;
      if (upd_taken) btb_v_q[up_bi] <= 1'b1;
      ghr_q <= ghr_d;
      br_q  <= br_d;
      mp_q  <= mp_d;
    end
  end
  always_ff @(posedge clk) begin
    if (reset && upd_en && upd_taken) begin
      btb_tag_q[up_bi] <= upd_pc[31:BTB_IDX_W+2];
      btb_tgt_q[up_bi] <= upd_target;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed table-driven and sequence checks of branch_predictor in bimodal and gshare modes
module tb_branch_predictor;
  logic        clk = 0;
  logic        reset = 0;
  logic [31:0] lk_pc = 0;
  logic        upd_en = 0;
  logic [31:0] upd_pc = 0;
  logic [7:0]  upd_pht_idx = 0;
  logic        upd_taken = 0;
  logic [31:0] upd_target = 0;
  logic        upd_mispred = 0;
  logic        pt0, hit0, pt1, hit1;
  logic [31:0] tgt0, tgt1, sb0, sm0, sb1, sm1;
  logic [7:0]  idx0, idx1;
  int          n_cmp = 0;
  int          n_bad = 0;
  always #5 clk = ~clk;
  branch_predictor #(.PHT_IDX_W(8), .BTB_IDX_W(6), .MODE(0), .GHR_W(8)) u0 (
    .clk(clk), .reset(reset), .lk_pc(lk_pc), .lk_pred_taken(pt0), .lk_btb_hit(hit0),
    .lk_target(tgt0), .lk_pht_idx(idx0), .upd_en(upd_en), .upd_pc(upd_pc),
    .upd_pht_idx(upd_pht_idx), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispred(upd_mispred), .stat_branches(sb0), .stat_mispreds(sm0));
  branch_predictor #(.PHT_IDX_W(8), .BTB_IDX_W(6), .MODE(1), .GHR_W(8)) u1 (
    .clk(clk), .reset(reset), .lk_pc(lk_pc), .lk_pred_taken(pt1), .lk_btb_hit(hit1),
    .lk_target(tgt1), .lk_pht_idx(idx1), .upd_en(upd_en), .upd_pc(upd_pc),
    .upd_pht_idx(upd_pht_idx), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispred(upd_mispred), .stat_branches(sb1), .stat_mispreds(sm1));
  typedef struct {
    logic        u;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk;
    logic [31:0] lk;
    logic        hit;
    logic        pt;
    logic [31:0] et;
  } vec_t;
  vec_t v [17];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  task automatic upd(input logic [31:0] pc, input logic [7:0] idx, input logic [31:0] tgt,
                     input logic tk, input logic mis);
    upd_pc = pc; upd_pht_idx = idx; upd_target = tgt; upd_taken = tk; upd_mispred = mis;
    upd_en = 1;
    @(posedge clk);
    #1 upd_en = 0;
  endtask
  task automatic do_reset();
    @(negedge clk) reset = 0;
    @(negedge clk) reset = 1;
  endtask
  localparam logic [31:0] A  = 32'h0040_0010;
  localparam logic [31:0] B  = 32'h0040_0110;
  localparam logic [31:0] TA = 32'h0040_0100;
  localparam logic [31:0] TB = 32'h0040_0200;
  initial begin
    v[0]  = '{0, A, TA, 0, A, 0, 0, 32'h0040_0014};
    v[1]  = '{1, A, TA, 1, A, 1, 1, TA};
    v[2]  = '{1, A, TA, 1, A, 1, 1, TA};
    v[3]  = '{1, A, TA, 0, A, 1, 1, TA};
    v[4]  = '{1, A, TA, 0, A, 1, 0, TA};
    v[5]  = '{1, A, TA, 1, A, 1, 1, TA};
    v[6]  = '{1, A, TA, 1, A, 1, 1, TA};
    v[7]  = '{1, A, TA, 1, A, 1, 1, TA};
    v[8]  = '{1, A, TA, 1, A, 1, 1, TA};
    v[9]  = '{1, A, TA, 1, A, 1, 1, TA};
    v[10] = '{1, A, TA, 0, A, 1, 1, TA};
    v[11] = '{1, A, TA, 0, A, 1, 0, TA};
    v[12] = '{1, A, TA, 0, A, 1, 0, TA};
    v[13] = '{1, A, TA, 0, A, 1, 0, TA};
    v[14] = '{1, A, TA, 1, A, 1, 0, TA};
    v[15] = '{1, B, TB, 1, A, 0, 0, 32'h0040_0014};
    v[16] = '{0, B, TB, 0, B, 1, 1, TB};
    reset = 0;
    lk_pc = A;
    #3;
    chk("reset_hit", {31'd0, hit0}, 32'd0);
    chk("reset_target", tgt0, 32'h0040_0014);
    do_reset();
    for (int i = 0; i < 17; i++) begin
      lk_pc = v[i].lk;
      if (v[i].u) upd(v[i].pc, v[i].pc[9:2], v[i].tgt, v[i].tk, 1'b0);
      #1;
      chk($sformatf("v%0d_hit", i), {31'd0, hit0}, {31'd0, v[i].hit});
      chk($sformatf("v%0d_pt", i), {31'd0, pt0}, {31'd0, v[i].pt});
      chk($sformatf("v%0d_tgt", i), tgt0, v[i].et);
    end
    chk("stat_branches_table", sb0, 32'd15);
    chk("stat_mispreds_table", sm0, 32'd0);
    // asynchronous reset mid-operation, updates ignored while held
    #2 reset = 0;
    #1;
    lk_pc = B;
    #1;
    chk("async_hit", {31'd0, hit0}, 32'd0);
    chk("async_pt", {31'd0, pt0}, 32'd0);
    chk("async_target", tgt0, 32'h0040_0114);
    chk("async_stat", sb0, 32'd0);
    upd(B, B[9:2], TB, 1'b1, 1'b1);
    #1;
    chk("held_hit", {31'd0, hit0}, 32'd0);
    chk("held_stat", sb0, 32'd0);
    @(negedge clk) reset = 1;
    #1;
    chk("post_reset_hit", {31'd0, hit0}, 32'd0);
    // gshare history: T,T,NT -> GHR 0x06
    upd(A, 8'h04, TA, 1'b1, 1'b0);
    upd(A, 8'h04, TA, 1'b1, 1'b0);
    upd(A, 8'h04, TA, 1'b0, 1'b0);
    lk_pc = 32'h0040_0000;
    #1;
    chk("gshare_idx", {24'd0, idx1}, 32'h06);
    chk("bimodal_idx", {24'd0, idx0}, 32'h00);
    lk_pc = A;
    #1;
    chk("bimodal_idx_a", {24'd0, idx0}, 32'h04);
    chk("gshare_idx_a", {24'd0, idx1}, 32'h02);
    upd_mispred = 1;
    @(posedge clk);
    #1;
    chk("idle_hold_br", sb0, 32'd3);
    chk("idle_hold_mp", sm0, 32'd0);
    // same-cycle lookup/update of index 4, counter 01, BTB primed via another PHT index
    do_reset();
    upd(A, 8'h09, TA, 1'b1, 1'b1);
    lk_pc = A;
    upd_pc = A; upd_pht_idx = 8'h04; upd_target = TA; upd_taken = 1; upd_mispred = 0;
    upd_en = 1;
    #1;
    chk("same_cyc_hit", {31'd0, hit0}, 32'd1);
    chk("same_cyc_pt_before", {31'd0, pt0}, 32'd0);
    @(posedge clk);
    #1 upd_en = 0;
    chk("same_cyc_pt_after", {31'd0, pt0}, 32'd1);
    upd(A, 8'h04, TA, 1'b1, 1'b1);
    chk("stat_branches", sb0, 32'd3);
    chk("stat_mispreds", sm0, 32'd2);
    chk("stat_branches_g", sb1, 32'd3);
    chk("stat_mispreds_g", sm1, 32'd2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
